// File: rtl/profile_counter_pkg.sv
// Shared definitions for the profile counter bank.
// Contents: command opcodes, per-channel FSM state encoding, and the
// channel-index width helper ch_w(n) = max(1, $clog2(n)).
package profile_counter_pkg;

  localparam logic [1:0] OP_START    = 2'b00;
  localparam logic [1:0] OP_STOP     = 2'b01;
  localparam logic [1:0] OP_CLEAR    = 2'b10;
  localparam logic [1:0] OP_SNAPSHOT = 2'b11;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } chan_state_e;

  function automatic int unsigned ch_w(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/profile_channel.sv
// One profiling channel: STOPPED/RUNNING FSM, up/down counter with bound
// detection, sticky overflow flag and snapshot shadow registers.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   event_i, dir_i      count strobe and direction (1 = up)
//   start_i, stop_i     decoded START/STOP for this channel
//   clear_i             decoded CLEAR for this channel
//   snap_i              global SNAPSHOT strobe
//   running_o           1 while RUNNING
//   overflow_o          live sticky overflow flag
//   shadow_o            captured count
//   shadow_ovf_o        captured overflow flag
module profile_channel
  import profile_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             event_i,
  input  logic             dir_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic             snap_i,
  output logic             running_o,
  output logic             overflow_o,
  output logic [WIDTH-1:0] shadow_o,
  output logic             shadow_ovf_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  chan_state_e      state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] shadow_q;
  logic             shadow_ovf_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOPPED: if (start_i) state_d = ST_RUNNING;
      ST_RUNNING: if (stop_i)  state_d = ST_STOPPED;
      default:    state_d = ST_STOPPED;
    endcase
  end

  // Counting looks at the pre-edge state, so an event alongside STOP is
  // counted and one alongside START is not.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (state_q == ST_RUNNING && event_i) begin
      if (dir_i) begin
        if (count_q == '1) begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? count_q : '0;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q == '0) begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? count_q : '1;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_STOPPED;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      shadow_q     <= '0;
      shadow_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (snap_i) begin
        shadow_q     <= count_q;
        shadow_ovf_q <= ovf_q;
      end
    end
  end

  assign running_o    = (state_q == ST_RUNNING);
  assign overflow_o   = ovf_q;
  assign shadow_o     = shadow_q;
  assign shadow_ovf_o = shadow_ovf_q;

endmodule

// File: rtl/profile_counter_bank.sv
// Bank of CHANNELS up/down profiling counters with one command port,
// a global snapshot into shadow registers, and a 1-cycle shadow read port.
// Optional feature macro: PROFILE_COUNTER_IRQ_EN (adds irqMask register,
// loaded by cmdOp=11 with cmdChannel all-ones; irq = |(overflow & mask)).
// Ports:
//   clock_i, reset_i          clock, synchronous active-high reset
//   event_i, direction_i      per-channel count strobe / direction
//   cmdValid_i, cmdOp_i       command strobe and opcode
//   cmdChannel_i              command target channel
//   readReq_i, readChannel_i  shadow read request and index
//   readValid_o, readData_o   read response (1 cycle after request)
//   readOverflow_o            shadow overflow flag of the read channel
//   running_o                 per-channel RUNNING status
//   irq_o                     overflow interrupt (0 when feature absent)
module profile_counter_bank
  import profile_counter_pkg::*;
#(
  parameter  int unsigned WIDTH    = 32,
  parameter  int unsigned CHANNELS = 4,
  parameter  bit          SATURATE = 1'b0,
  localparam int unsigned CH_W     = ch_w(CHANNELS)
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [CHANNELS-1:0] event_i,
  input  logic [CHANNELS-1:0] direction_i,
  input  logic                cmdValid_i,
  input  logic [1:0]          cmdOp_i,
  input  logic [CH_W-1:0]     cmdChannel_i,
  input  logic                readReq_i,
  input  logic [CH_W-1:0]     readChannel_i,
  output logic                readValid_o,
  output logic [WIDTH-1:0]    readData_o,
  output logic                readOverflow_o,
  output logic [CHANNELS-1:0] running_o,
  output logic                irq_o
);

  logic [CHANNELS-1:0] sel;
  logic [CHANNELS-1:0] start_v, stop_v, clear_v;
  logic                snap;
  logic [CHANNELS-1:0] ovf_v;
  logic [CHANNELS-1:0] shadow_ovf;
  logic [WIDTH-1:0]    shadow [CHANNELS];

  // One-hot channel select; an out-of-range index matches nothing and is
  // therefore ignored without a separate range check.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cmdChannel_i == i[CH_W-1:0]) sel[i] = 1'b1;
    end
  end

  always_comb begin
    start_v = '0;
    stop_v  = '0;
    clear_v = '0;
    if (cmdValid_i) begin
      unique case (cmdOp_i)
        OP_START: start_v = sel;
        OP_STOP:  stop_v  = sel;
        OP_CLEAR: clear_v = sel;
        default:  ;
      endcase
    end
  end

`ifdef PROFILE_COUNTER_IRQ_EN
  logic [CHANNELS-1:0] mask_q;
  logic                irq_q;
  logic                mask_wr;

  assign mask_wr = cmdValid_i && (cmdOp_i == OP_SNAPSHOT) && (cmdChannel_i == '1);
  assign snap    = cmdValid_i && (cmdOp_i == OP_SNAPSHOT) && (cmdChannel_i != '1);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (mask_wr) mask_q <= event_i;
      irq_q <= |(ovf_v & mask_q);
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_ovf;

  assign snap       = cmdValid_i && (cmdOp_i == OP_SNAPSHOT);
  assign unused_ovf = ^ovf_v;
  assign irq_o      = 1'b0;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    profile_channel #(
      .WIDTH   (WIDTH),
      .SATURATE(SATURATE)
    ) u_chan (
      .clk_i       (clock_i),
      .rst_i       (reset_i),
      .event_i     (event_i[g]),
      .dir_i       (direction_i[g]),
      .start_i     (start_v[g]),
      .stop_i      (stop_v[g]),
      .clear_i     (clear_v[g]),
      .snap_i      (snap),
      .running_o   (running_o[g]),
      .overflow_o  (ovf_v[g]),
      .shadow_o    (shadow[g]),
      .shadow_ovf_o(shadow_ovf[g])
    );
  end

  logic [WIDTH-1:0] rd_data_d;
  logic             rd_ovf_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_ovf_q;
  logic             rd_valid_q;

  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (readChannel_i == i[CH_W-1:0]) begin
        rd_data_d = shadow[i];
        rd_ovf_d  = shadow_ovf[i];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
    end else begin
      rd_valid_q <= readReq_i;
      if (readReq_i) begin
        rd_data_q <= rd_data_d;
        rd_ovf_q  <= rd_ovf_d;
      end
    end
  end

  assign readValid_o    = rd_valid_q;
  assign readData_o     = rd_data_q;
  assign readOverflow_o = rd_ovf_q;

endmodule

// File: tb/tb_profile_counter_bank.sv
// Scoreboard bench: two 4-bit, 3-channel instances (wrap and saturate) share
// stimulus; expected read responses are queued per instance and checked by
// a monitor whenever readValid is seen.
module tb_profile_counter_bank;

  localparam int unsigned W  = 4;
  localparam int unsigned CH = 3;

  typedef struct {
    logic [W-1:0] d;
    logic         o;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] ev, dir;
  logic          cmdValid;
  logic [1:0]    cmdOp;
  logic [1:0]    cmdCh;
  logic          readReq;
  logic [1:0]    readCh;

  logic          rv_w, ro_w, irq_w, rv_s, ro_s, irq_s;
  logic [W-1:0]  rd_w, rd_s;
  logic [CH-1:0] run_w, run_s;

  exp_t q_w[$];
  exp_t q_s[$];
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  profile_counter_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1'b0)) dut_w (
    .clock_i(clk), .reset_i(rst), .event_i(ev), .direction_i(dir),
    .cmdValid_i(cmdValid), .cmdOp_i(cmdOp), .cmdChannel_i(cmdCh),
    .readReq_i(readReq), .readChannel_i(readCh),
    .readValid_o(rv_w), .readData_o(rd_w), .readOverflow_o(ro_w),
    .running_o(run_w), .irq_o(irq_w)
  );

  profile_counter_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1'b1)) dut_s (
    .clock_i(clk), .reset_i(rst), .event_i(ev), .direction_i(dir),
    .cmdValid_i(cmdValid), .cmdOp_i(cmdOp), .cmdChannel_i(cmdCh),
    .readReq_i(readReq), .readChannel_i(readCh),
    .readValid_o(rv_s), .readData_o(rd_s), .readOverflow_o(ro_s),
    .running_o(run_s), .irq_o(irq_s)
  );

  // Monitor: every readValid must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rv_w) begin
      vectors++;
      if (q_w.size() == 0) begin
        errors++;
        $display("FAIL rd_wrap: unexpected readValid data=%0d ovf=%0b", rd_w, ro_w);
      end else begin
        e = q_w.pop_front();
        if (rd_w !== e.d || ro_w !== e.o) begin
          errors++;
          $display("FAIL rd_wrap: got data=%0d ovf=%0b want data=%0d ovf=%0b", rd_w, ro_w, e.d, e.o);
        end
      end
    end
    if (rv_s) begin
      vectors++;
      if (q_s.size() == 0) begin
        errors++;
        $display("FAIL rd_sat: unexpected readValid data=%0d ovf=%0b", rd_s, ro_s);
      end else begin
        e = q_s.pop_front();
        if (rd_s !== e.d || ro_s !== e.o) begin
          errors++;
          $display("FAIL rd_sat: got data=%0d ovf=%0b want data=%0d ovf=%0b", rd_s, ro_s, e.d, e.o);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0; ev = '0; dir = '0; cmdValid = 1'b0; cmdOp = 2'b00;
    cmdCh = 2'd0; readReq = 1'b0; readCh = 2'd0;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [1:0] ch);
    cmdValid = 1'b1; cmdOp = op; cmdCh = ch;
    tick();
  endtask

  task automatic pulses(input logic [CH-1:0] m, input logic [CH-1:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      ev = m; dir = d;
      tick();
    end
  endtask

  task automatic expect_rd(input logic [W-1:0] dw, input logic ow,
                           input logic [W-1:0] ds, input logic os);
    exp_t a, b;
    a.d = dw; a.o = ow; b.d = ds; b.o = os;
    q_w.push_back(a);
    q_s.push_back(b);
  endtask

  task automatic rd(input logic [1:0] ch, input logic [W-1:0] dw, input logic ow,
                    input logic [W-1:0] ds, input logic os);
    expect_rd(dw, ow, ds, os);
    readReq = 1'b1; readCh = ch;
    tick();
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  initial begin
    rst = 1'b1; ev = '0; dir = '0; cmdValid = 1'b0; cmdOp = 2'b00;
    cmdCh = 2'd0; readReq = 1'b0; readCh = 2'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Reset state
    chk("reset_running_w", {5'd0, run_w}, 8'h00);
    chk("reset_running_s", {5'd0, run_s}, 8'h00);
    chk("reset_rvalid", {6'd0, rv_w, rv_s}, 8'h00);
    chk("reset_irq", {6'd0, irq_w, irq_s}, 8'h00);
    rd(2'd0, 4'd0, 1'b0, 4'd0, 1'b0);

    // ch0: 5 up events, snapshot, read
    cmd(2'b00, 2'd0);
    chk("start_ch0", {5'd0, run_w}, 8'h01);
    pulses(3'b001, 3'b001, 5);
    cmd(2'b11, 2'd0);
    rd(2'd0, 4'd5, 1'b0, 4'd5, 1'b0);

    // ch1: 15 ups then one more -> wrap vs hold, overflow set
    cmd(2'b00, 2'd1);
    chk("start_ch1", {5'd0, run_s}, 8'h03);
    pulses(3'b010, 3'b010, 15);
    cmd(2'b11, 2'd0);
    rd(2'd1, 4'd15, 1'b0, 4'd15, 1'b0);
    pulses(3'b010, 3'b010, 1);
    cmd(2'b11, 2'd0);
    rd(2'd1, 4'd0, 1'b1, 4'd15, 1'b1);
    chk("irq_default_off", {6'd0, irq_w, irq_s}, 8'h00);

    // ch2: down from 0, then CLEAR with same-cycle event
    cmd(2'b00, 2'd2);
    pulses(3'b100, 3'b000, 1);
    cmd(2'b11, 2'd0);
    rd(2'd2, 4'd15, 1'b1, 4'd0, 1'b1);
    ev = 3'b100; dir = 3'b100;
    cmd(2'b10, 2'd2);
    cmd(2'b11, 2'd0);
    rd(2'd2, 4'd0, 1'b0, 4'd0, 1'b0);
    chk("clear_keeps_run", {5'd0, run_w}, 8'h07);

    // ch0 reuse: STOP/START with same-cycle events
    cmd(2'b10, 2'd0);
    pulses(3'b001, 3'b001, 3);
    ev = 3'b001; dir = 3'b001;
    cmd(2'b01, 2'd0);
    chk("stop_ch0", {5'd0, run_w}, 8'h06);
    pulses(3'b001, 3'b001, 2);
    cmd(2'b11, 2'd0);
    rd(2'd0, 4'd4, 1'b0, 4'd4, 1'b0);
    ev = 3'b001; dir = 3'b001;
    cmd(2'b00, 2'd0);
    pulses(3'b001, 3'b001, 3);
    ev = 3'b001; dir = 3'b001;
    cmd(2'b11, 2'd0);
    rd(2'd0, 4'd7, 1'b0, 4'd7, 1'b0);
    cmd(2'b11, 2'd0);
    rd(2'd0, 4'd8, 1'b0, 4'd8, 1'b0);
    pulses(3'b001, 3'b001, 1);
    // read and snapshot in the same cycle -> old shadow
    expect_rd(4'd8, 1'b0, 4'd8, 1'b0);
    readReq = 1'b1; readCh = 2'd0;
    cmd(2'b11, 2'd0);
    rd(2'd0, 4'd9, 1'b0, 4'd9, 1'b0);

    // Out-of-range channel: commands ignored, read returns zeros
    cmd(2'b01, 2'd3);
    chk("oor_stop_ignored", {5'd0, run_w}, 8'h07);
    cmd(2'b10, 2'd3);
    cmd(2'b11, 2'd0);
    rd(2'd1, 4'd0, 1'b1, 4'd15, 1'b1);
    rd(2'd3, 4'd0, 1'b0, 4'd0, 1'b0);

    // Reset while running with a read request in the same cycle
    rst = 1'b1; readReq = 1'b1; readCh = 2'd0; ev = 3'b111; dir = 3'b111;
    tick();
    chk("rst_running_w", {5'd0, run_w}, 8'h00);
    chk("rst_running_s", {5'd0, run_s}, 8'h00);
    chk("rst_rvalid", {6'd0, rv_w, rv_s}, 8'h00);
    cmd(2'b11, 2'd0);
    rd(2'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    rd(2'd1, 4'd0, 1'b0, 4'd0, 1'b0);
    rd(2'd2, 4'd0, 1'b0, 4'd0, 1'b0);

    repeat (3) tick();
    while (q_w.size() != 0) begin
      void'(q_w.pop_front());
      vectors++; errors++;
      $display("FAIL rd_wrap: expected response never arrived");
    end
    while (q_s.size() != 0) begin
      void'(q_s.pop_front());
      vectors++; errors++;
      $display("FAIL rd_sat: expected response never arrived");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
